// File: rtl/heartaware_pkg.sv
// Shared encodings for the signal capture block: mode selects and the
// capture FSM state type.
package heartaware_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_ROLL   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ROLL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

endpackage

// File: rtl/sample_strobe_gen.sv
// Sample strobe generator: one registered strobe every max(divider,1) clocks.
// A divider lowered below the running count strobes and restarts at once.
module sample_strobe_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] divider,
    output logic        strobe
);

    logic [31:0] w_div;
    logic        w_term;
    logic [31:0] r_cnt;
    logic        r_strobe;

    // Effective divider and terminal-count detect.
    always_comb begin
        w_div  = (divider == 32'd0) ? 32'd1 : divider;
        w_term = (r_cnt >= (w_div - 32'd1));
    end

    // Free-running sample counter with registered strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 32'd0;
            r_strobe <= 1'b0;
        end else begin
            r_cnt    <= w_term ? 32'd0 : (r_cnt + 32'd1);
            r_strobe <= w_term;
        end
    end

    assign strobe = r_strobe;

endmodule

// File: rtl/signal_capture.sv
// Multi-channel capture buffer with free-running roll mode and a single-shot
// rising-edge triggered mode holding POST_SAMPLES samples after the trigger.
module signal_capture
    import heartaware_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int DEPTH        = 1024,
    parameter  int CHANNELS     = 2,
    parameter  int POST_SAMPLES = 512,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               sample_divider,
    input  logic [CHANNELS*WIDTH-1:0] channel_in,
    input  logic [1:0]                mode,
    input  logic                      arm,
    input  logic [1:0]                trig_channel,
    input  logic [WIDTH-1:0]          trig_level,
    input  logic [AW-1:0]             rd_addr,
    input  logic [1:0]                rd_channel,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic [2:0]                state,
    output logic [AW:0]               fill,
    output logic                      triggered,
    output logic                      done
);

    localparam logic [AW:0]   L_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_FILL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   L_PRE_MIN   = (AW+1)'(DEPTH - POST_SAMPLES);
    localparam logic [AW-1:0] L_POST_LOAD = AW'(POST_SAMPLES);
    localparam logic [AW-1:0] L_PTR_ONE   = AW'(1);

    function automatic logic [WIDTH-1:0] f_chan_sel(
        input logic [CHANNELS*WIDTH-1:0] word,
        input logic [1:0]                ch
    );
        logic [WIDTH-1:0] sel;
        sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch == 2'(c)) begin
                sel = word[c*WIDTH +: WIDTH];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    cap_state_e                r_state, w_next_state;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW:0]               r_fill;
    logic [AW-1:0]             r_post_cnt;
    logic [WIDTH-1:0]          r_prev;
    logic                      r_triggered;
    logic                      r_done;
    logic [WIDTH-1:0]          r_rd_data;
    logic                      r_rd_valid;
    logic [CHANNELS*WIDTH-1:0] r_mem [DEPTH];

    logic             w_strobe;
    logic             w_we;
    logic             w_clear;
    logic             w_trig;
    logic             w_trig_hit;
    logic [WIDTH-1:0] w_trig_sample;
    logic [AW-1:0]    w_rd_phys;

    sample_strobe_gen u_strobe (
        .clk     (clk),
        .reset   (reset),
        .divider (sample_divider),
        .strobe  (w_strobe)
    );

    // Trigger qualification and logical-to-physical read mapping.
    always_comb begin
        w_trig_sample = f_chan_sel(channel_in, trig_channel);
        w_trig_hit    = (r_fill >= L_PRE_MIN) && (r_prev < trig_level)
                        && (w_trig_sample >= trig_level);
        w_rd_phys     = (r_fill == L_DEPTH) ? (r_wr_ptr + rd_addr) : rd_addr;
    end

    // Capture FSM next-state and write/clear decode; arm beats a same-cycle strobe.
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_clear      = 1'b0;
        w_trig       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mode == MODE_ROLL) begin
                    w_next_state = ST_ROLL;
                    w_clear      = 1'b1;
                end else if (arm && (mode == MODE_SINGLE)) begin
                    w_next_state = ST_ARMED;
                    w_clear      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ROLL: begin
                if (mode != MODE_ROLL) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_we = w_strobe;
                end
            end
            ST_ARMED: begin
                if (mode != MODE_SINGLE) begin
                    w_next_state = ST_IDLE;
                end else if (arm) begin
                    w_clear = 1'b1;
                end else if (w_strobe) begin
                    w_we   = 1'b1;
                    w_trig = w_trig_hit;
                    w_next_state = w_trig_hit ? ST_POST : ST_ARMED;
                end else begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_POST: begin
                if (mode != MODE_SINGLE) begin
                    w_next_state = ST_IDLE;
                end else if (arm) begin
                    w_next_state = ST_ARMED;
                    w_clear      = 1'b1;
                end else if (w_strobe) begin
                    w_we = 1'b1;
                    w_next_state = (r_post_cnt == L_PTR_ONE) ? ST_DONE : ST_POST;
                end else begin
                    w_next_state = ST_POST;
                end
            end
            ST_DONE: begin
                if (mode != MODE_SINGLE) begin
                    w_next_state = ST_IDLE;
                end else if (arm) begin
                    w_next_state = ST_ARMED;
                    w_clear      = 1'b1;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write pointer, fill, post counter, previous sample and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_post_cnt  <= '0;
            r_prev      <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_triggered <= w_trig;
            r_done      <= (w_next_state == ST_DONE);
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_fill   <= '0;
                r_prev   <= '0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
                r_fill   <= (r_fill == L_DEPTH) ? r_fill : (r_fill + L_FILL_ONE);
                r_prev   <= w_trig_sample;
            end
            if (w_trig) begin
                r_post_cnt <= L_POST_LOAD;
            end else if (w_we && (r_state == ST_POST)) begin
                r_post_cnt <= r_post_cnt - L_PTR_ONE;
            end
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= channel_in;
        end
    end

    // Registered read port; sees pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= f_chan_sel(r_mem[w_rd_phys], rd_channel);
            r_rd_valid <= ({1'b0, rd_addr} < r_fill);
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign state     = r_state;
    assign fill      = r_fill;
    assign triggered = r_triggered;
    assign done      = r_done;

endmodule

// File: tb/tb_signal_capture.sv
// Directed bench for signal_capture with a 16-deep buffer and 8 post-trigger samples.
module tb_signal_capture;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int CHANNELS = 2;
    localparam int POST     = 8;
    localparam int AW       = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [31:0]               sample_divider;
    logic [CHANNELS*WIDTH-1:0] channel_in;
    logic [1:0]                mode;
    logic                      arm;
    logic [1:0]                trig_channel;
    logic [WIDTH-1:0]          trig_level;
    logic [AW-1:0]             rd_addr;
    logic [1:0]                rd_channel;
    logic [WIDTH-1:0]          rd_data;
    logic                      rd_valid;
    logic [2:0]                state;
    logic [AW:0]               fill;
    logic                      triggered;
    logic                      done;

    int n_checks = 0;
    int n_errors = 0;
    int f0;
    logic [7:0] gate [10];

    signal_capture #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .CHANNELS     (CHANNELS),
        .POST_SAMPLES (POST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_divider (sample_divider),
        .channel_in     (channel_in),
        .mode           (mode),
        .arm            (arm),
        .trig_channel   (trig_channel),
        .trig_level     (trig_level),
        .rd_addr        (rd_addr),
        .rd_channel     (rd_channel),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .state          (state),
        .fill           (fill),
        .triggered      (triggered),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input logic [7:0] c0, input logic [7:0] c1);
        channel_in = {c1, c0};
    endtask

    initial begin
        reset = 1'b1; sample_divider = 32'd4; channel_in = 16'h0000; mode = 2'b00;
        arm = 1'b0; trig_channel = 2'd0; trig_level = 8'h80; rd_addr = 4'd0; rd_channel = 2'd0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Divider 4 then 0, measured as fill growth in roll mode.
        mode = 2'b01;
        tick(); tick();
        check("roll_state", 32'(state), 32'd1);
        f0 = int'(fill);
        repeat (16) tick();
        check("div4_rate", 32'(int'(fill) - f0), 32'd4);
        sample_divider = 32'd0;
        tick(); tick();
        f0 = int'(fill);
        repeat (5) tick();
        check("div0_rate", 32'(int'(fill) - f0), 32'd5);

        // Roll wrap with a 20-sample ramp.
        mode = 2'b00;
        tick();
        check("freeze_idle", 32'(state), 32'd0);
        mode = 2'b01;
        tick();
        check("roll_clear", 32'(fill), 32'd0);
        for (int k = 0; k < 20; k++) begin
            set_ch(8'(k), 8'(8'h40 + k));
            tick();
        end
        mode = 2'b00;
        check("roll_fill", 32'(fill), 32'd16);
        tick();
        rd_channel = 2'd0; rd_addr = 4'd0;
        tick();
        check("roll_rd0", 32'(rd_data), 32'h04);
        check("roll_valid", 32'(rd_valid), 32'd1);
        rd_addr = 4'd15;
        tick();
        check("roll_rd15", 32'(rd_data), 32'h13);
        rd_channel = 2'd1;
        tick();
        check("roll_rd15_ch1", 32'(rd_data), 32'h53);

        // Single capture, triggering on channel 1 while channel 0 sits high.
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        tick(); tick();
        trig_channel = 2'd1; trig_level = 8'h80; mode = 2'b10; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_state", 32'(state), 32'd2);
        check("arm_fill", 32'(fill), 32'd0);
        for (int k = 0; k < 19; k++) begin
            set_ch(8'hFF, 8'(8'h76 + k));
            tick();
            check("single_trig", 32'(triggered), 32'(k == 10));
            if (k == 10) check("single_post", 32'(state), 32'd3);
            if (k == 17) check("single_not_done", 32'(done), 32'd0);
            if (k == 18) check("single_done_state", 32'(state), 32'd4);
            if (k == 18) check("single_done", 32'(done), 32'd1);
        end
        rd_channel = 2'd1; rd_addr = 4'd7;
        tick();
        check("single_trig_sample", 32'(rd_data), 32'h80);
        rd_addr = 4'd0;
        tick();
        check("single_oldest", 32'(rd_data), 32'h79);
        check("single_hold_fill", 32'(fill), 32'd16);
        check("single_hold_state", 32'(state), 32'd4);

        // Pre-fill gate: early crossing is ignored.
        gate[0] = 8'h10; gate[1] = 8'h20; gate[2] = 8'h30; gate[3] = 8'h90; gate[4] = 8'h20;
        gate[5] = 8'h20; gate[6] = 8'h20; gate[7] = 8'h20; gate[8] = 8'h20; gate[9] = 8'h90;
        trig_channel = 2'd0; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_done_fill", 32'(fill), 32'd0);
        for (int i = 0; i < 10; i++) begin
            set_ch(gate[i], 8'h00);
            tick();
            check("gate_trig", 32'(triggered), 32'(i == 9));
        end
        check("gate_post", 32'(state), 32'd3);

        // Re-arm mid-POST.
        set_ch(8'h20, 8'h00);
        tick(); tick();
        check("post_before_arm", 32'(state), 32'd3);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_state", 32'(state), 32'd2);
        check("rearm_fill", 32'(fill), 32'd0);

        // Reset mid-POST.
        for (int i = 0; i < 8; i++) begin
            set_ch(8'h00, 8'h00);
            tick();
        end
        set_ch(8'h90, 8'h00);
        tick();
        check("retrig", 32'(triggered), 32'd1);
        set_ch(8'h10, 8'h00);
        rd_addr = 4'd0; rd_channel = 2'd0;
        tick(); tick();
        check("pre_rst_post", 32'(state), 32'd3);
        check("pre_rst_valid", 32'(rd_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_fill", 32'(fill), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        reset = 1'b0;

        // Read/write collision at the oldest slot of a full roll buffer.
        mode = 2'b00;
        tick(); tick();
        mode = 2'b01;
        tick();
        for (int k = 0; k < 16; k++) begin
            set_ch(8'(8'h30 + k), 8'h00);
            tick();
        end
        set_ch(8'hA0, 8'h00);
        rd_addr = 4'd0; rd_channel = 2'd0;
        tick();
        check("collide_old", 32'(rd_data), 32'h30);
        mode = 2'b00; rd_addr = 4'd15;
        tick();
        check("collide_new", 32'(rd_data), 32'hA0);
        check("collide_idle", 32'(state), 32'd0);
        rd_addr = 4'd1;
        tick(); tick();
        check("frozen_rd1", 32'(rd_data), 32'h32);
        check("frozen_fill", 32'(fill), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/signal_capture.md
SIGNAL_CAPTURE -- requirements
Module: signal_capture

Interface
REQ-001 Parameter WIDTH, 8: sample width in bits.
REQ-002 Parameter DEPTH, 1024: samples per channel; power of two; AW = log2(DEPTH).
REQ-003 Parameter CHANNELS, 2: independent input channels, 1..4.
REQ-004 Parameter POST_SAMPLES, 512: samples written after the trigger sample; 1..DEPTH-1.
REQ-005 clk  in  1  system clock (clk_100mhz domain); the single clock; reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 sample_divider  in  32  clk cycles per sample strobe; 0 is treated as 1.
REQ-008 channel_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 mode  in  2  00 IDLE/freeze, 01 ROLL, 10 SINGLE triggered, 11 reserved (same as 00).
REQ-010 arm  in  1  single-cycle pulse; starts or restarts a SINGLE capture.
REQ-011 trig_channel  in  2  channel compared against trig_level.
REQ-012 trig_level  in  WIDTH  unsigned rising-edge threshold.
REQ-013 rd_addr  in  AW  logical read index; 0 is the oldest stored sample.
REQ-014 rd_channel  in  2  channel to read.
REQ-015 rd_data  out  WIDTH  read data, registered.
REQ-016 rd_valid  out  1  high when the registered rd_addr is below fill.
REQ-017 state  out  3  current FSM state encoding.
REQ-018 fill  out  AW+1  stored sample count, saturating at DEPTH.
REQ-019 triggered  out  1  one-cycle pulse on the strobe that accepts the trigger.
REQ-020 done  out  1  high while in DONE.

Function
REQ-021 Strobe: a counter runs 0..max(sample_divider,1)-1 and strobes on the terminal count; when the counter is already at or beyond a lowered divider, it strobes and restarts the next cycle.
REQ-022 On each strobe in a writing state, all channels are written at physical address wr_ptr; wr_ptr then increments modulo DEPTH; fill increments, saturating at DEPTH.
REQ-023 FSM states: IDLE, ROLL, ARMED, POST, DONE.
REQ-024 Writing states: ROLL, ARMED, POST. No writes occur in IDLE or DONE.
REQ-025 IDLE -> ROLL when mode=01; fill and wr_ptr are cleared on entry to ROLL.
REQ-026 IDLE or DONE -> ARMED on arm with mode=10; clears fill, wr_ptr and the previous-sample register.
REQ-027 Arm in ARMED or POST restarts ARMED with the same clearing.
REQ-028 Trigger condition: on a strobe in ARMED, with fill >= DEPTH-POST_SAMPLES, prev < trig_level and current >= trig_level on trig_channel.
REQ-029 On the trigger: the current sample is written, triggered pulses, state -> POST, and post_cnt is loaded with POST_SAMPLES.
REQ-030 POST: each strobe writes and decrements post_cnt; the strobe that writes the last sample moves state to DONE.
REQ-031 ROLL, ARMED, POST or DONE -> IDLE within one cycle when mode leaves the value that owns the state; buffer contents and fill are retained (freeze).
REQ-032 Read physical address = (fill==DEPTH ? wr_ptr + rd_addr : rd_addr) mod DEPTH.
REQ-033 rd_data and rd_valid appear exactly 1 cycle after rd_addr/rd_channel are presented.
REQ-034 A read and a write to the same physical address in the same cycle return the old data (read-first).
REQ-035 Arm and a strobe in the same cycle: arm wins; that strobe is not written.
REQ-036 The previous-sample register updates on every write strobe, whether or not a trigger is accepted.

Reset
REQ-037 Reset puts the FSM in IDLE and clears wr_ptr, fill, post_cnt, the strobe counter, prev, triggered, done, rd_valid and rd_data.
REQ-038 Buffer RAM contents are not cleared by reset.
REQ-039 Reset takes priority over every other input, including mid-POST.

Structure
REQ-040 The package heartaware_pkg holds the mode encodings and the capture FSM state typedef/constants.
REQ-041 The strobe counter is a sub-module, sample_strobe_gen (clk, reset, divider -> strobe).
REQ-042 Storage is one inferred simple-dual-port RAM of CHANNELS*WIDTH bits x DEPTH.

Verification
REQ-043 Divider: sample_divider=4 -> a strobe every 4th clk; sample_divider=0 -> a strobe every clk.
REQ-044 Roll wrap: DEPTH=16, mode=01, ramp 0,1,2.. for 20 strobes -> fill=16, rd_addr 0 reads 4, rd_addr 15 reads 19.
REQ-045 Single capture: DEPTH=16, POST=8, trig_level=0x80, ramp crossing 0x80 after 10 strobes -> triggered once; DONE after 8 more strobes; rd_addr 7 holds the trigger sample 0x80.
REQ-046 Pre-fill gate: trig_level crossed at strobe 3 (fill<8) -> no trigger; the next crossing after fill>=8 triggers.
REQ-047 Re-arm and reset: arm mid-POST -> ARMED with fill=0; reset mid-POST -> IDLE with fill=0 and rd_valid=0 on the next cycle.
REQ-048 Collision: read the address being written this cycle -> the old value is returned, and the new value is returned one cycle later.
